// File: rtl/btn_event_pkg.sv
// Shared event-code layout and helpers for the button event queue.
package btn_event_pkg;

  localparam int EV_W         = 8;
  localparam int EV_VALID_BIT = 7;
  localparam int EV_PRESS_BIT = 6;
  localparam int EV_IDX_LSB   = 0;
  localparam int EV_IDX_W     = 2;

  typedef logic [EV_W-1:0] ev_t;

  // Code returned when a pop finds nothing queued; its valid bit is clear.
  localparam ev_t EV_EMPTY = 8'h00;

  // Build an event code: valid, direction (1 = press), button index.
  function automatic ev_t ev_make(input logic press, input logic [EV_IDX_W-1:0] idx);
    ev_t ev;
    ev                            = '0;
    ev[EV_VALID_BIT]              = 1'b1;
    ev[EV_PRESS_BIT]              = press;
    ev[EV_IDX_LSB +: EV_IDX_W]    = idx;
    return ev;
  endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Synchronous event FIFO. A push while full is accepted only when a pop
// happens in the same cycle, so a full queue can drain and refill at once.
module btn_event_fifo
  import btn_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  ev_t                    push_data,
  input  logic                   pop,
  output ev_t                    head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ev_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is deliberately not reset; the count and pointers
  // decide which entries are meaningful, and a reset mux per entry buys nothing.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_queue.sv
// Turns debounced button edges into press/release event codes, queues them
// in order and hands them out one per start/done transaction.
module btn_event_queue
  import btn_event_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BTN_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [BTN_WIDTH-1:0]   btn_stable,
  input  logic                   start_port,
  output logic                   done_port,
  output logic [7:0]             out1,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow
);

  logic [BTN_WIDTH-1:0] prev;
  logic [BTN_WIDTH-1:0] pending;
  logic [BTN_WIDTH-1:0] pend_dir;

  logic [BTN_WIDTH-1:0] edges;
  logic [BTN_WIDTH-1:0] ser_clear;
  logic [BTN_WIDTH-1:0] pending_next;
  logic [BTN_WIDTH-1:0] pend_dir_next;
  logic [BTN_WIDTH-1:0] lost;

  logic                 ser_found;
  logic [EV_IDX_W-1:0]  ser_idx;
  logic                 ser_dir;

  logic                 fifo_full;
  logic                 fifo_empty;
  ev_t                  fifo_head;
  logic                 fifo_push;
  logic                 fifo_pop;
  ev_t                  push_data;

  assign edges     = btn_stable ^ prev;
  assign fifo_pop  = start_port && !fifo_empty;
  // A full FIFO still accepts the serializer's event when a pop frees a slot.
  assign fifo_push = ser_found && (!fifo_full || fifo_pop);
  assign push_data = ev_make(ser_dir, ser_idx);

  // Pick the lowest-numbered pending button; scanning downward lets the
  // lowest index overwrite any higher one found earlier.
  // NOTE: every output of this block gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ser_found = 1'b0;
    ser_idx   = '0;
    ser_dir   = 1'b0;
    for (int i = BTN_WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        ser_found = 1'b1;
        ser_idx   = EV_IDX_W'(i);
        ser_dir   = pend_dir[i];
      end
    end
  end

  // Pending-bit bookkeeping: a fresh edge always wins over the bit being
  // serialized, and an edge that lands on an unserialized pending bit is lost.
  always_comb begin
    ser_clear = '0;
    for (int i = 0; i < BTN_WIDTH; i++) begin
      ser_clear[i] = fifo_push && (ser_idx == EV_IDX_W'(i));
    end
    pending_next  = edges | (pending & ~ser_clear);
    pend_dir_next = (edges & btn_stable) | (~edges & pend_dir);
    lost          = edges & pending & ~ser_clear;
  end

  // Edge stage and serializer state, plus the sticky loss flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev     <= '0;
      pending  <= '0;
      pend_dir <= '0;
      overflow <= 1'b0;
    end else begin
      prev     <= btn_stable;
      pending  <= pending_next;
      pend_dir <= pend_dir_next;
      if (|lost) overflow <= 1'b1;
    end
  end

  // Pop handshake: answer every start one cycle later and hold the answer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_port <= 1'b0;
      out1      <= EV_EMPTY;
    end else begin
      done_port <= start_port;
      if (start_port) out1 <= fifo_empty ? EV_EMPTY : fifo_head;
    end
  end

  btn_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (ev_count)
  );

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue with a scoreboard of expected pop results.
module tb_btn_event_queue;

  logic       clock      = 1'b0;
  logic       reset      = 1'b0;
  logic [3:0] btn_stable = 4'b0000;
  logic       start_port = 1'b0;
  logic       done_port;
  logic [7:0] out1;
  logic [2:0] ev_count;
  logic       overflow;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  btn_event_queue #(
    .DEPTH     (4),
    .BTN_WIDTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_stable (btn_stable),
    .start_port (start_port),
    .done_port  (done_port),
    .out1       (out1),
    .ev_count   (ev_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n clock edges; inputs change and state is read 1 ns after each edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one start and queue the result the monitor should see.
  task automatic pop_one(input logic [7:0] exp);
    exp_q.push_back(exp);
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done_port) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got out1=%h, expected no response", out1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out1", {24'h0, out1}, {24'h0, mon_exp});
      end
    end
  end

  initial begin
    // Reset state.
    tick(3);
    check("rst_done",     {31'h0, done_port}, 32'h0);
    check("rst_out1",     {24'h0, out1},      32'h0);
    check("rst_ev_count", {29'h0, ev_count},  32'h0);
    check("rst_overflow", {31'h0, overflow},  32'h0);
    reset = 1'b1;
    tick();

    // Single press.
    btn_stable = 4'b0001;
    tick(3);
    check("press_count", {29'h0, ev_count}, 32'd1);
    pop_one(8'hC0);
    check("press_drained", {29'h0, ev_count}, 32'd0);

    // Release.
    btn_stable = 4'b0000;
    tick(3);
    check("release_count", {29'h0, ev_count}, 32'd1);
    pop_one(8'h80);

    // Simultaneous press, then a pop on an empty queue.
    btn_stable = 4'b0101;
    tick(3);
    check("simul_count", {29'h0, ev_count}, 32'd2);
    pop_one(8'hC0);
    pop_one(8'hC2);
    pop_one(8'h00);
    check("simul_drained", {29'h0, ev_count}, 32'd0);

    // New edge on the bit being serialized: both events kept, no loss.
    btn_stable = 4'b0100;
    tick();
    btn_stable = 4'b0101;
    tick(3);
    check("same_bit_count",    {29'h0, ev_count}, 32'd2);
    check("same_bit_overflow", {31'h0, overflow}, 32'h0);
    pop_one(8'h80);
    pop_one(8'hC0);

    // Fill to DEPTH without popping.
    btn_stable = 4'b0000;
    tick(3);
    btn_stable = 4'b1000;
    tick(3);
    btn_stable = 4'b1001;
    tick(3);
    check("fill_count",    {29'h0, ev_count}, 32'd4);
    check("fill_overflow", {31'h0, overflow}, 32'h0);

    // Toggle bit 1 twice while it cannot be serialized.
    btn_stable = 4'b1011;
    tick();
    btn_stable = 4'b1001;
    tick(2);
    check("ovf_flag",  {31'h0, overflow}, 32'h1);
    check("ovf_count", {29'h0, ev_count}, 32'd4);

    // Pop while full with an event pending: occupancy stays at DEPTH.
    pop_one(8'h80);
    check("full_pushpop_count", {29'h0, ev_count}, 32'd4);
    pop_one(8'h82);
    pop_one(8'hC3);
    pop_one(8'hC0);
    pop_one(8'h81);
    check("ovf_drained",  {29'h0, ev_count}, 32'd0);
    check("ovf_sticky",   {31'h0, overflow}, 32'h1);

    // Reset mid-operation with three events queued and a start in flight.
    btn_stable = 4'b0000;
    tick(3);
    btn_stable = 4'b0010;
    tick(3);
    check("pre_reset_count", {29'h0, ev_count}, 32'd3);
    reset      = 1'b0;
    start_port = 1'b1;
    tick();
    reset      = 1'b1;
    start_port = 1'b0;
    check("mid_rst_count",    {29'h0, ev_count},  32'd0);
    check("mid_rst_overflow", {31'h0, overflow},  32'h0);
    check("mid_rst_out1",     {24'h0, out1},      32'h0);
    check("mid_rst_done",     {31'h0, done_port}, 32'h0);

    // Button still held after reset shows up as a fresh press.
    tick(3);
    check("post_rst_count", {29'h0, ev_count}, 32'd1);
    pop_one(8'hC1);
    pop_one(8'h00);
    check("post_rst_overflow", {31'h0, overflow}, 32'h0);

    tick(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
